// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : Instruction-fetch stage. Owns the PC, drives the instruction
//             memory and loads the IF/ID pipeline register. Handles stalls,
//             redirects and parking on HLT. Optional FETCH_STATS_EN macro
//             adds saturating fetch/stall/redirect counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_instr,
    output logic [15:0] pc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_inc,
    output logic        if_id_valid,
    output logic        fetch_halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_fetch_cnt,
    output logic [15:0] stat_stall_cnt,
    output logic [15:0] stat_redirect_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_inc_q, pc_inc_d;
    logic        valid_q, valid_d;
    logic [15:0] w_pc_inc;
    logic        w_fetch;

    assign w_pc_inc = pc_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_inc_d = pc_inc_q;
        valid_d  = valid_q;
        w_fetch  = 1'b0;
        if (redirect_valid) begin
            pc_d     = redirect_addr;
            instr_d  = NOP_INSTR;
            pc_inc_d = 16'h0000;
            valid_d  = 1'b0;
            state_d  = ST_RUN;
        end else if (stall) begin
            // hold everything
        end else if (state_q == ST_HALTED) begin
            // the HLT was already delivered once; keep feeding bubbles
            instr_d  = NOP_INSTR;
            pc_inc_d = 16'h0000;
            valid_d  = 1'b0;
        end else begin
            w_fetch  = 1'b1;
            instr_d  = im_instr;
            pc_inc_d = w_pc_inc;
            valid_d  = 1'b1;
            if (im_instr[15:12] == HLT_OPCODE) begin
                state_d = ST_HALTED;
            end else begin
                pc_d = w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_inc_q <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= valid_d;
        end
    end

    assign pc           = pc_q;
    assign im_addr      = pc_q;
    assign im_rd_en     = (state_q == ST_RUN);
    assign if_id_instr  = instr_q;
    assign if_id_pc_inc = pc_inc_q;
    assign if_id_valid  = valid_q;
    assign fetch_halted = (state_q == ST_HALTED);

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q, redir_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
            redir_cnt_q <= 16'h0000;
        end else begin
            if (w_fetch && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (stall && !redirect_valid && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (redirect_valid && (redir_cnt_q != 16'hFFFF)) begin
                redir_cnt_q <= redir_cnt_q + 16'd1;
            end
        end
    end

    assign stat_fetch_cnt    = fetch_cnt_q;
    assign stat_stall_cnt    = stall_cnt_q;
    assign stat_redirect_cnt = redir_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Scoreboard bench for fetch_stage; directed vectors push hand
//             computed expectations, a negedge monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_inc;
    logic        if_id_valid;
    logic        fetch_halted;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_fetch_cnt, stat_stall_cnt, stat_redirect_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] inc;
        logic        valid;
        logic        halted;
        logic        rd_en;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_addr     (redirect_addr),
        .im_addr           (im_addr),
        .im_rd_en          (im_rd_en),
        .im_instr          (im_instr),
        .pc                (pc),
        .if_id_instr       (if_id_instr),
        .if_id_pc_inc      (if_id_pc_inc),
        .if_id_valid       (if_id_valid),
        .fetch_halted      (fetch_halted)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetch_cnt    (stat_fetch_cnt),
        .stat_stall_cnt    (stat_stall_cnt),
        .stat_redirect_cnt (stat_redirect_cnt)
`endif
    );

    // Instruction memory: 0..2 fixed, 9 is HLT, other low addresses 16'h40xx,
    // anything above 16'h00FF reads 16'h5555.
    logic [15:0] imem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h4000 | 16'(i);
        imem[0] = 16'h1123;
        imem[1] = 16'h2234;
        imem[2] = 16'h3345;
        imem[9] = 16'hF000;
    end
    assign im_instr = (im_addr[15:8] == 8'h00) ? imem[im_addr[7:0]] : 16'h5555;

    // Monitor: one expectation per cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = '{pc: pc, instr: if_id_instr, inc: if_id_pc_inc,
                  valid: if_id_valid, halted: fetch_halted, rd_en: im_rd_en};
            checks++;
            if (a !== e || im_addr !== e.pc) begin
                errors++;
                $display("FAIL cycle_state t=%0t: got pc=%h im_addr=%h instr=%h inc=%h v=%b h=%b rd=%b, want pc=%h instr=%h inc=%h v=%b h=%b rd=%b",
                         $time, a.pc, im_addr, a.instr, a.inc, a.valid, a.halted, a.rd_en,
                         e.pc, e.instr, e.inc, e.valid, e.halted, e.rd_en);
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] ra,
                        input logic [15:0] ep, input logic [15:0] ei, input logic [15:0] einc,
                        input logic ev, input logic eh);
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        exp_q.push_back('{pc: ep, instr: ei, inc: einc, valid: ev, halted: eh, rd_en: !eh});
        @(posedge clk);
        #1;
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //    rst s  rv  raddr     pc        instr     inc       v  h
        step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);  // reset
        step(0, 0, 0, 16'h0000, 16'h0001, 16'h1123, 16'h0001, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0002, 16'h2234, 16'h0002, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0003, 16'h3345, 16'h0003, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0004, 16'h4003, 16'h0004, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0005, 16'h4004, 16'h0005, 1, 0);
        step(0, 1, 0, 16'h0000, 16'h0005, 16'h4004, 16'h0005, 1, 0);  // stall x2
        step(0, 1, 0, 16'h0000, 16'h0005, 16'h4004, 16'h0005, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0006, 16'h4005, 16'h0006, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0007, 16'h4006, 16'h0007, 1, 0);
        step(0, 1, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 0, 0);  // redirect beats stall
        step(0, 0, 0, 16'h0000, 16'h0041, 16'h4040, 16'h0041, 1, 0);
        step(0, 0, 1, 16'h0009, 16'h0009, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 0, 16'h0000, 16'h0009, 16'hF000, 16'h000A, 1, 1);  // HLT delivered once
        step(0, 0, 0, 16'h0000, 16'h0009, 16'h0000, 16'h0000, 0, 1);
        step(0, 1, 0, 16'h0000, 16'h0009, 16'h0000, 16'h0000, 0, 1);
        step(0, 0, 0, 16'h0000, 16'h0009, 16'h0000, 16'h0000, 0, 1);
        step(0, 0, 1, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 0, 0);  // leave HALTED
        step(0, 0, 0, 16'h0000, 16'h0021, 16'h4020, 16'h0021, 1, 0);
        step(0, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 16'h5555, 16'h0000, 1, 0);  // wrap
        step(0, 0, 0, 16'h0000, 16'h0001, 16'h1123, 16'h0001, 1, 0);
        step(0, 0, 1, 16'h0009, 16'h0009, 16'h0000, 16'h0000, 0, 0);
        step(0, 0, 0, 16'h0000, 16'h0009, 16'hF000, 16'h000A, 1, 1);
        step(1, 0, 1, 16'h0033, 16'h0000, 16'h0000, 16'h0000, 0, 0);  // reset beats redirect/HALTED
        step(0, 0, 0, 16'h0000, 16'h0001, 16'h1123, 16'h0001, 1, 0);
        step(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);  // reset beats stall
        step(0, 0, 0, 16'h0000, 16'h0001, 16'h1123, 16'h0001, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0002, 16'h2234, 16'h0002, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0003, 16'h3345, 16'h0003, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0004, 16'h4003, 16'h0004, 1, 0);
        step(0, 1, 0, 16'h0000, 16'h0004, 16'h4003, 16'h0004, 1, 0);
        step(0, 1, 0, 16'h0000, 16'h0004, 16'h4003, 16'h0004, 1, 0);
        step(0, 0, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 0, 0);
`ifdef FETCH_STATS_EN
        check16("stat_fetch_cnt",    stat_fetch_cnt,    16'd4);
        check16("stat_stall_cnt",    stat_stall_cnt,    16'd2);
        check16("stat_redirect_cnt", stat_redirect_cnt, 16'd1);
`endif
        step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
`ifdef FETCH_STATS_EN
        check16("stat_fetch_cnt_rst",    stat_fetch_cnt,    16'd0);
        check16("stat_stall_cnt_rst",    stat_stall_cnt,    16'd0);
        check16("stat_redirect_cnt_rst", stat_redirect_cnt, 16'd0);
`endif
        step(0, 0, 0, 16'h0000, 16'h0001, 16'h1123, 16'h0001, 1, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
